// File: rtl/de0_keys_pkg.sv
// Shared types and default timing constants for the DE0-Nano key conditioner.
package de0_keys_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } key_st_e;

  localparam int CLK_HZ              = 50000000;
  localparam int DB_CYCLES_10MS      = CLK_HZ / 100;
  localparam int REPEAT_DELAY_500MS  = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_100MS = CLK_HZ / 10;

  // Counter width able to hold 0..v-1, never narrower than one bit
  function automatic int cnt_width(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, counter debounce FSM, press/release
// pulses and, when KEY_REPEAT_EN is defined, an auto-repeat pulse generator.
module key_debounce_ch
  import de0_keys_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_10MS,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_debounce_ch: DB_CYCLES must be >= 2, repeat timings >= 1");
  end

  logic          s1_q, s2_q;
  logic          p;
  key_st_e       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Plain two-flop synchronizer; idles at raw 1 (released)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= key_n_i;
      s2_q <= s1_q;
    end
  end

  assign p = ~s2_q;

  // Debounce state, counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q      <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state: a change is accepted only after DB_CYCLES stable samples;
  // the counter stops at CNT_LAST because the state leaves WAIT_* there
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (st_q)
      UP: begin
        if (p) begin
          st_d  = WAIT_DN;
          cnt_d = '0;
        end
      end
      WAIT_DN: begin
        if (!p) begin
          st_d = UP;
        end else if (cnt_q == CNT_LAST) begin
          st_d    = DOWN;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!p) begin
          st_d  = WAIT_UP;
          cnt_d = '0;
        end
      end
      WAIT_UP: begin
        if (p) begin
          st_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          st_d      = UP;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = UP;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_REPEAT_EN
  localparam int            RW       = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                 REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rfirst_q, rfirst_d;
  logic          repeat_q, repeat_d;

  // Repeat timer state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
      repeat_q <= repeat_d;
    end
  end

  // Restart on an accepted press; advance only while staying in DOWN so a
  // release bounce (WAIT_UP) freezes the timer and resumes it on return
  always_comb begin
    rcnt_d   = rcnt_q;
    rfirst_d = rfirst_q;
    repeat_d = 1'b0;
    if (press_d) begin
      rcnt_d   = '0;
      rfirst_d = 1'b0;
    end else if (st_q == DOWN && p) begin
      if (rcnt_q == (rfirst_q ? PER_LAST : DLY_LAST)) begin
        repeat_d = 1'b1;
        rcnt_d   = '0;
        rfirst_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// DE0-Nano push-button conditioner: raw active-low KEY pins in, clean
// active-high level and one-cycle press/release/repeat pulses out.
// Define KEY_REPEAT_EN to build the auto-repeat timers.
module key_conditioner
  import de0_keys_pkg::*;
#(
  parameter int NUM_KEYS      = 2,
  parameter int DB_CYCLES     = DB_CYCLES_10MS,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MS
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  // Fully independent channels, one per key
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (CLOCK_50),
      .rst_ni   (RESET_N),
      .key_n_i  (KEY[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .repeat_o (key_repeat[g])
    );
  end

endmodule
